hs_rr_arbiter: RTL and testbench



---
 rtl/hs_arb_pkg.sv | 21 ++
 rtl/hs_rr_arbiter_rr_pick.sv | 35 +++
 rtl/hs_rr_arbiter.sv | 169 ++++++++++++++++
 tb/tb_hs_rr_arbiter.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/hs_arb_pkg.sv
// Shared types and defaults for the handshake round-robin arbiter.
//   arb_state_e : arbitration FSM state (ARB = free arbitration, LOCK = grant
//                 pinned to one requester for the rest of its burst)
//   DEF_N_REQ   : default number of requester ports
//   DEF_DATA_W  : default data width per beat
//   wrap_inc    : index + 1, wrapping n-1 -> 0
package hs_arb_pkg;

    typedef enum logic [0:0] {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    localparam int unsigned DEF_N_REQ  = 4;
    localparam int unsigned DEF_DATA_W = 32;

    function automatic int unsigned wrap_inc(input int unsigned idx, input int unsigned n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/hs_rr_arbiter_rr_pick.sv
// Combinational round-robin selector.
//   req     : request vector, one bit per requester
//   ptr     : highest-priority index; search runs ptr, ptr+1, ... wrapping to 0
//   gnt_vld : at least one request present
//   gnt_idx : index of the first requesting port found from ptr upward
module rr_pick
    import hs_arb_pkg::*;
#(
    parameter int unsigned N_REQ = DEF_N_REQ,
    parameter int unsigned SRC_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [SRC_W-1:0] ptr,
    output logic             gnt_vld,
    output logic [SRC_W-1:0] gnt_idx
);

    always_comb begin
        int unsigned cand;
        gnt_vld = 1'b0;
        gnt_idx = '0;
        cand    = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = 32'(ptr) + k;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!gnt_vld && req[cand[SRC_W-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand[SRC_W-1:0];
            end
        end
    end

endmodule

// File: rtl/hs_rr_arbiter.sv
// Round-robin arbiter sharing one valid/ready channel between N_REQ requesters.
// The winning beat is registered into a single output stage (latency 1, up to
// one beat per cycle); out_valid is never dropped before out_ready.
//
// Ports:
//   clk       : clock, rising edge
//   reset_n   : asynchronous reset, active low
//   in_valid  : per-requester valid
//   in_data   : per-requester data, requester i at [i*DATA_W +: DATA_W]
//   in_last   : per-requester end-of-burst flag
//   in_ready  : per-requester ready, one-hot or zero
//   out_valid : registered beat valid
//   out_data  : registered beat data
//   out_src   : index of the requester that sourced the beat
//   out_last  : registered in_last of the beat
//   out_ready : slave ready
//
// Configuration macro HS_ARB_BURST_LOCK_EN: when defined, a beat accepted with
// in_last=0 pins the grant to its requester until that requester's in_last=1
// beat is accepted. When undefined every beat is arbitrated independently and
// in_last is only forwarded to out_last.
module hs_rr_arbiter
    import hs_arb_pkg::*;
#(
    parameter  int unsigned N_REQ  = DEF_N_REQ,
    parameter  int unsigned DATA_W = DEF_DATA_W,
    localparam int unsigned SRC_W  = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        in_valid,
    input  logic [N_REQ*DATA_W-1:0] in_data,
    input  logic [N_REQ-1:0]        in_last,
    output logic [N_REQ-1:0]        in_ready,
    output logic                    out_valid,
    output logic [DATA_W-1:0]       out_data,
    output logic [SRC_W-1:0]        out_src,
    output logic                    out_last,
    input  logic                    out_ready
);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [SRC_W-1:0]  ptr_q;
    logic [SRC_W-1:0]  ptr_next;
    logic [N_REQ-1:0]  lock_mask;
    logic [N_REQ-1:0]  req_eff;
    logic              gnt_vld;
    logic [SRC_W-1:0]  gnt_idx;
    logic              stage_free;
    logic              accept;
    logic              gnt_last;
    logic [DATA_W-1:0] gnt_data;

`ifdef HS_ARB_BURST_LOCK_EN
    logic [SRC_W-1:0]  lock_id_q;

    always_comb begin
        lock_mask = '0;
        lock_mask[lock_id_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock_id_q <= '0;
        end else if (accept && state_q == ARB) begin
            lock_id_q <= gnt_idx;
        end
    end
`else
    assign lock_mask = '0;
`endif

    // FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ARB;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
`ifdef HS_ARB_BURST_LOCK_EN
        if (accept) begin
            case (state_q)
                ARB:     if (!gnt_last) state_d = LOCK;
                LOCK:    if (gnt_last)  state_d = ARB;
                default: state_d = ARB;
            endcase
        end
`endif
    end

    // FSM output: which requests may compete this cycle
    always_comb begin
        req_eff = '0;
        case (state_q)
            ARB:     req_eff = in_valid;
            LOCK:    req_eff = in_valid & lock_mask;
            default: req_eff = '0;
        endcase
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .SRC_W (SRC_W)
    ) u_pick (
        .req     (req_eff),
        .ptr     (ptr_q),
        .gnt_vld (gnt_vld),
        .gnt_idx (gnt_idx)
    );

    // reset_n is folded in so in_ready is forced low for as long as reset is
    // asserted, not just from the next edge.
    always_comb begin
        stage_free = !out_valid || out_ready;
        accept     = gnt_vld && stage_free && reset_n;
        in_ready   = '0;
        if (accept) begin
            in_ready[gnt_idx] = 1'b1;
        end
    end

    always_comb begin
        gnt_data = '0;
        gnt_last = 1'b0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt_idx == SRC_W'(i)) begin
                gnt_data = in_data[i*DATA_W +: DATA_W];
                gnt_last = in_last[i];
            end
        end
    end

    assign ptr_next = SRC_W'(wrap_inc(32'(gnt_idx), N_REQ));

    // Pointer advances past the winner on every arbitrated beat; inside a
    // locked burst it only moves once the closing beat is taken.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if (accept && (state_q == ARB || gnt_last)) begin
            ptr_q <= ptr_next;
        end
    end

    // Output stage: reload on accept (covers simultaneous drain), else clear
    // valid once the slave has taken the beat; payload held otherwise.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            out_last  <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= gnt_data;
            out_src   <= gnt_idx;
            out_last  <= gnt_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_hs_rr_arbiter.sv
module tb_hs_rr_arbiter;

    localparam int unsigned N = 4;
    localparam int unsigned W = 32;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [N-1:0]   in_valid;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_last;
    logic [N-1:0]   in_ready;
    logic           out_valid;
    logic [W-1:0]   out_data;
    logic [1:0]     out_src;
    logic           out_last;
    logic           out_ready;

    int vectors     = 0;
    int miscompares = 0;

    hs_rr_arbiter #(.N_REQ(N), .DATA_W(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_last  (out_last),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] dval(input int i);
        return 32'hC0DE_0000 + 32'(i) * 32'h111;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_src [5];
        int exp_last[5];
        int nb;
        int beat_cnt;
        logic acc1;

`ifdef HS_ARB_BURST_LOCK_EN
        exp_src  = '{1, 1, 1, 0, 0};
        exp_last = '{0, 0, 1, 0, 0};
        nb = 4;
`else
        exp_src  = '{1, 0, 1, 0, 1};
        exp_last = '{0, 0, 0, 0, 1};
        nb = 5;
`endif

        for (int i = 0; i < int'(N); i++) in_data[i*W +: W] = dval(i);
        reset_n   = 1'b0;
        in_valid  = 4'b1111;
        in_last   = 4'b0000;
        out_ready = 1'b0;
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  out_data,       32'd0);
        chk("rst_out_src",   32'(out_src),   32'd0);
        chk("rst_out_last",  32'(out_last),  32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        step();
        chk("rst_hold_valid", 32'(out_valid), 32'd0);

        // all requesters busy, slave always ready
        reset_n   = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rr_first_ready", 32'(in_ready), 32'b0001);
        for (int k = 0; k < 6; k++) begin
            step();
            chk("rr_valid", 32'(out_valid), 32'd1);
            chk("rr_src",   32'(out_src),   32'(k % 4));
            chk("rr_data",  out_data,       dval(k % 4));
            chk("rr_ready", 32'(in_ready),  32'(1 << ((k + 1) % 4)));
        end

        // slave stall: last beat was from req1, pointer at 2
        out_ready = 1'b0;
        #1;
        chk("stall_ready0", 32'(in_ready), 32'd0);
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_src",   32'(out_src),   32'd1);
            chk("stall_data",  out_data,       dval(1));
            chk("stall_ready", 32'(in_ready),  32'd0);
        end
        out_ready = 1'b1;
        #1;
        chk("unstall_ready", 32'(in_ready), 32'b0100);
        step();
        chk("unstall_valid", 32'(out_valid), 32'd1);
        chk("unstall_src",   32'(out_src),   32'd2);
        chk("unstall_data",  out_data,       dval(2));

        // only req2 requesting
        in_valid = 4'b0100;
        #1;
        chk("solo_ready0", 32'(in_ready), 32'b0100);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("solo_valid", 32'(out_valid), 32'd1);
            chk("solo_src",   32'(out_src),   32'd2);
            chk("solo_ready", 32'(in_ready),  32'b0100);
        end
        in_valid = 4'b0000;
        step();
        chk("idle_valid", 32'(out_valid), 32'd0);
        chk("idle_ready", 32'(in_ready),  32'd0);

        // move pointer to 2 via req1, then reset mid-stream
        in_valid = 4'b0010;
        step();
        chk("pre_rst_src", 32'(out_src), 32'd1);
        in_valid = 4'b1111;
        reset_n  = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_src",   32'(out_src),   32'd0);
        chk("arst_ready", 32'(in_ready),  32'd0);
        step();
        reset_n = 1'b1;
        #1;
        chk("post_rst_ready", 32'(in_ready), 32'b0001);
        step();
        chk("post_rst_src",  32'(out_src), 32'd0);
        chk("post_rst_data", out_data,     dval(0));

        // req1 3-beat burst, req0 joins after req1's first beat
        in_valid = 4'b0010;
        in_last  = 4'b0000;
        beat_cnt = 0;
        #1;
        for (int j = 0; j < nb; j++) begin
            acc1 = in_valid[1] & in_ready[1];
            step();
            chk("burst_valid", 32'(out_valid), 32'd1);
            chk("burst_src",   32'(out_src),   32'(exp_src[j]));
            chk("burst_last",  32'(out_last),  32'(exp_last[j]));
            chk("burst_data",  out_data,       dval(exp_src[j]));
            if (acc1) beat_cnt++;
            in_valid[0] = 1'b1;
            in_valid[1] = (beat_cnt < 3);
            in_last[1]  = (beat_cnt == 2);
            #1;
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
